// File: rtl/proc_result_fifo.sv
// proc_result_fifo
// Captures every new {cy, acc} result from the processor core as a 9-bit record.
// Records go into a small FIFO that a host or checker drains over valid/ready.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   acc[7:0]   processor accumulator
//   cy         processor carry flag
//   cap_en     capture enable (change detection and pushes only while high)
//   clr_ovf    synchronous clear of the sticky overflow flag
//   out_data   registered head record {cy, acc}, meaningful while out_valid
//   out_valid  FIFO not empty
//   out_ready  consumer accepts the head record when high together with out_valid
//   count      number of stored records, 0..DEPTH
//   overflow   sticky: a record was dropped because the FIFO was full
module proc_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    acc,
    input  logic          cy,
    input  logic          cap_en,
    input  logic          clr_ovf,
    output logic [8:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [8:0]    head_q, head_d;
    logic [8:0]    last_q, last_d;
    logic          primed_q, primed_d;
    logic          ovf_q, ovf_d;

    logic [8:0]    sample;
    logic [AW-1:0] rptr_inc;
    logic          full;
    logic          empty;
    logic          push_req;
    logic          pop;
    logic          push_ok;
    logic          ovf_evt;

    assign sample   = {cy, acc};
    assign rptr_inc = rptr_q + AW'(1);
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);

    // The first enabled sample after reset always pushes, even if it equals the reset value of last_q.
    assign push_req = cap_en && (!primed_q || (sample != last_q));
    assign pop      = !empty && out_ready;
    // A simultaneous pop frees a slot, so a full FIFO can still accept.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_evt  = push_req && full && !pop;

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        head_d   = head_q;
        last_d   = last_q;
        primed_d = primed_q;
        ovf_d    = ovf_q;

        if (push_ok) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_inc;
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // out_data is a register: it only moves on a pop, or when the first record lands in an empty FIFO.
        // With exactly one record being popped, the next head is the record pushed this same cycle.
        if (pop) begin
            if (count_q > CW'(1)) begin
                head_d = mem_q[rptr_inc];
            end else if (push_ok) begin
                head_d = sample;
            end
        end else if (empty && push_ok) begin
            head_d = sample;
        end

        // The change detector tracks every enabled sample, whether or not the push was accepted.
        if (cap_en) begin
            last_d   = sample;
            primed_d = 1'b1;
        end

        // A new drop outranks a clear in the same cycle.
        if (ovf_evt) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            head_q   <= '0;
            last_q   <= '0;
            primed_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            last_q   <= last_d;
            primed_q <= primed_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: every entry is written before count makes it visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= sample;
        end
    end

    assign out_data  = head_q;
    assign out_valid = !empty;
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule
